// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch/execute handshake, write-back and debug signals of the decode stage
interface decode_pipe_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [31:0]     in_pc;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_pc;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;
  modport master (
    output in_valid, in_inst, in_pc, wb_en, wb_addr, wb_data, flush, out_ready, dbg_addr,
    input  in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data, out_imm,
           out_illegal, dbg_data
  );
  modport slave (
    input  in_valid, in_inst, in_pc, wb_en, wb_addr, wb_data, flush, out_ready, dbg_addr,
    output in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data, out_imm,
           out_illegal, dbg_data
  );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: RV32 decode stage with register file, write-back bypass and valid/ready output register
module decode_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          rst,
  decode_pipe_if.slave bus
);
  localparam int AW = NREG > 1 ? $clog2(NREG) : 1;
  logic [XLEN-1:0] r_rf [NREG];
  logic            r_valid;
  logic [31:0]     r_pc;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic            r_illegal;
  logic [31:0]     w_inst;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rf1;
  logic [XLEN-1:0] w_rf2;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_load;
  logic            w_wb_ok;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_hhit1;
  logic            w_hhit2;
  function automatic logic ok(input logic [4:0] a);
    return a != 5'd0 && 32'(a) < NREG;
  endfunction
  assign w_inst     = bus.in_inst;
  assign w_op       = w_inst[6:0];
  assign w_f3       = w_inst[14:12];
  assign w_rs1      = w_inst[19:15];
  assign w_rs2      = w_inst[24:20];
  assign w_wb_ok    = bus.wb_en && ok(bus.wb_addr);
  assign w_hit1     = w_wb_ok && bus.wb_addr == w_rs1;
  assign w_hit2     = w_wb_ok && bus.wb_addr == w_rs2;
  assign w_hhit1    = w_wb_ok && bus.wb_addr == r_inst[19:15];
  assign w_hhit2    = w_wb_ok && bus.wb_addr == r_inst[24:20];
  assign w_rf1      = ok(w_rs1) ? r_rf[w_rs1[AW-1:0]] : '0;
  assign w_rf2      = ok(w_rs2) ? r_rf[w_rs2[AW-1:0]] : '0;
  assign w_rs1_data = (BYPASS != 0 && w_hit1) ? bus.wb_data : w_rf1;
  assign w_rs2_data = (BYPASS != 0 && w_hit2) ? bus.wb_data : w_rf2;
  assign bus.in_ready = !bus.flush && (!r_valid || bus.out_ready);
  assign w_load       = bus.in_valid && bus.in_ready;
  assign bus.dbg_data = ok(bus.dbg_addr) ? r_rf[bus.dbg_addr[AW-1:0]] : '0;
  always_comb begin
    w_imm     = '0;
    w_illegal = 1'b0;
    case (w_op)
      7'b0000011, 7'b1100111: w_imm = XLEN'($signed(w_inst[31:20]));
      7'b0010011: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) w_imm = XLEN'(w_inst[24:20]);
        else w_imm = XLEN'($signed(w_inst[31:20]));
      end
      7'b0100011: w_imm = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
      7'b1100011: w_imm = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
      7'b0110111, 7'b0010111: w_imm = XLEN'($signed({w_inst[31:12], 12'b0}));
      7'b1101111: w_imm = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));
      7'b0110011, 7'b1110011, 7'b0001111: w_imm = '0;
      default: w_illegal = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_inst     <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_illegal  <= 1'b0;
    end else begin
      if (w_wb_ok) r_rf[bus.wb_addr[AW-1:0]] <= bus.wb_data;
      if (bus.flush) r_valid <= 1'b0;
      else if (w_load) begin
        r_valid    <= 1'b1;
        r_pc       <= bus.in_pc;
        r_inst     <= w_inst;
        r_rs1_data <= w_rs1_data;
        r_rs2_data <= w_rs2_data;
        r_imm      <= w_imm;
        r_illegal  <= w_illegal;
      end else if (r_valid && !bus.out_ready) begin
        // a stalled instruction must not miss write-backs to its own sources
        if (w_hhit1) r_rs1_data <= bus.wb_data;
        if (w_hhit2) r_rs2_data <= bus.wb_data;
      end else r_valid <= 1'b0;
    end
  end
  assign bus.out_valid    = r_valid;
  assign bus.out_pc       = r_pc;
  assign bus.out_inst     = r_inst;
  assign bus.out_rs1_data = r_rs1_data;
  assign bus.out_rs2_data = r_rs2_data;
  assign bus.out_imm      = r_imm;
  assign bus.out_illegal  = r_illegal;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: two configurations (32/32/bypass and 64/16/no-bypass) checked against a value-level model
module tb_decode_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [63:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  dbg_addr = '0;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  decode_pipe_if #(.XLEN(32)) ba ();
  decode_pipe_if #(.XLEN(64)) bb ();
  assign ba.in_valid = in_valid;
  assign ba.in_inst = in_inst;
  assign ba.in_pc = in_pc;
  assign ba.wb_en = wb_en;
  assign ba.wb_addr = wb_addr;
  assign ba.wb_data = wb_data[31:0];
  assign ba.flush = flush;
  assign ba.out_ready = out_ready;
  assign ba.dbg_addr = dbg_addr;
  assign bb.in_valid = in_valid;
  assign bb.in_inst = in_inst;
  assign bb.in_pc = in_pc;
  assign bb.wb_en = wb_en;
  assign bb.wb_addr = wb_addr;
  assign bb.wb_data = wb_data;
  assign bb.flush = flush;
  assign bb.out_ready = out_ready;
  assign bb.dbg_addr = dbg_addr;
  decode_pipe #(.XLEN(32), .NREG(32), .BYPASS(1)) ua (.clk(clk), .rst(rst), .bus(ba));
  decode_pipe #(.XLEN(64), .NREG(16), .BYPASS(0)) ub (.clk(clk), .rst(rst), .bus(bb));
  int          xl [2] = '{32, 64};
  int          nr [2] = '{32, 16};
  bit          bp [2] = '{1'b1, 1'b0};
  logic [63:0] mrf [2][32];
  logic        mv [2];
  logic [31:0] mpc [2];
  logic [31:0] minst [2];
  logic [63:0] mr1 [2];
  logic [63:0] mr2 [2];
  logic [63:0] mimm [2];
  logic        mill [2];
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] msk(input int c);
    return xl[c] == 32 ? 64'hFFFF_FFFF : '1;
  endfunction
  function automatic logic [63:0] rd(input int c, input logic [4:0] a);
    return (a == 0 || int'(a) >= nr[c]) ? 64'd0 : mrf[c][a];
  endfunction
  function automatic logic hit(input int c, input logic [4:0] a);
    return wb_en && wb_addr == a && a != 0 && int'(a) < nr[c];
  endfunction
  function automatic logic legal(input logic [6:0] op);
    return op inside {7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F};
  endfunction
  // immediates as signed offsets: sum of field weights minus the sign weight
  function automatic logic [63:0] imm_of(input logic [31:0] x);
    longint s;
    s = x[31] ? 64'd1 : 64'd0;
    case (x[6:0])
      7'h03, 7'h67: return longint'(x[31:20]) - s * 4096;
      7'h13: return (x[14:12] == 3'd1 || x[14:12] == 3'd5) ? longint'(x[24:20]) : longint'(x[31:20]) - s * 4096;
      7'h23: return longint'(x[31:25]) * 32 + longint'(x[11:7]) - s * 4096;
      7'h63: return longint'(x[7]) * 2048 + longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2 - s * 4096;
      7'h37, 7'h17: return longint'(x[31:12]) * 4096 - s * 64'h1_0000_0000;
      7'h6F: return longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048 + longint'(x[30:21]) * 2 - s * 1048576;
      default: return 64'd0;
    endcase
  endfunction
  task automatic mstep(input int c);
    logic ld;
    if (rst) begin
      for (int i = 0; i < 32; i++) mrf[c][i] = '0;
      mv[c] = 0; mpc[c] = 0; minst[c] = 0; mr1[c] = 0; mr2[c] = 0; mimm[c] = 0; mill[c] = 0;
    end else begin
      ld = in_valid && !flush && (!mv[c] || out_ready);
      if (flush) mv[c] = 0;
      else if (ld) begin
        mv[c] = 1;
        mpc[c] = in_pc;
        minst[c] = in_inst;
        mr1[c] = (bp[c] && hit(c, in_inst[19:15])) ? wb_data & msk(c) : rd(c, in_inst[19:15]);
        mr2[c] = (bp[c] && hit(c, in_inst[24:20])) ? wb_data & msk(c) : rd(c, in_inst[24:20]);
        mimm[c] = imm_of(in_inst) & msk(c);
        mill[c] = !legal(in_inst[6:0]);
      end else if (mv[c] && !out_ready) begin
        if (hit(c, minst[c][19:15])) mr1[c] = wb_data & msk(c);
        if (hit(c, minst[c][24:20])) mr2[c] = wb_data & msk(c);
      end else mv[c] = 0;
      if (wb_en && wb_addr != 0 && int'(wb_addr) < nr[c]) mrf[c][wb_addr] = wb_data & msk(c);
    end
  endtask
  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end
  always @(negedge clk) begin
    if (mon) begin
      chk("a_valid", 64'(ba.out_valid), 64'(mv[0]));
      chk("a_in_ready", 64'(ba.in_ready), 64'(!flush && (!mv[0] || out_ready)));
      chk("a_dbg", 64'(ba.dbg_data), rd(0, dbg_addr));
      chk("b_valid", 64'(bb.out_valid), 64'(mv[1]));
      chk("b_in_ready", 64'(bb.in_ready), 64'(!flush && (!mv[1] || out_ready)));
      chk("b_dbg", bb.dbg_data, rd(1, dbg_addr));
      if (mv[0]) begin
        chk("a_pc", 64'(ba.out_pc), 64'(mpc[0]));
        chk("a_inst", 64'(ba.out_inst), 64'(minst[0]));
        chk("a_rs1", 64'(ba.out_rs1_data), mr1[0]);
        chk("a_rs2", 64'(ba.out_rs2_data), mr2[0]);
        chk("a_imm", 64'(ba.out_imm), mimm[0]);
        chk("a_ill", 64'(ba.out_illegal), 64'(mill[0]));
      end
      if (mv[1]) begin
        chk("b_pc", 64'(bb.out_pc), 64'(mpc[1]));
        chk("b_inst", 64'(bb.out_inst), 64'(minst[1]));
        chk("b_rs1", bb.out_rs1_data, mr1[1]);
        chk("b_rs2", bb.out_rs2_data, mr2[1]);
        chk("b_imm", bb.out_imm, mimm[1]);
        chk("b_ill", 64'(bb.out_illegal), 64'(mill[1]));
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  logic [31:0] sw_inst [6] = '{32'h01F09093, 32'h4030D093, 32'hFE000EE3, 32'h800000B7, 32'h0010006F, 32'h0000007F};
  logic [63:0] sw_a [6] = '{64'h1F, 64'h3, 64'hFFFF_FFFC, 64'h8000_0000, 64'h800, 64'h0};
  logic [63:0] sw_b [6] = '{64'h1F, 64'h3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_8000_0000, 64'h800, 64'h0};
  logic        sw_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  initial begin
    tick;
    tick;
    rst = 1'b0;
    mon = 1'b1;
    chk("rst_valid", 64'(ba.out_valid), 64'd0);
    chk("rst_inst", 64'(ba.out_inst), 64'd0);
    chk("rst_in_ready", 64'(ba.in_ready), 64'd1);
    chk("rst_b_imm", bb.out_imm, 64'd0);
    out_ready = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h1234;
    tick;
    wb_en = 1'b0;
    in_valid = 1'b1; in_inst = 32'h000280B3; in_pc = 32'h100;
    tick;
    in_valid = 1'b0;
    chk("add_valid", 64'(ba.out_valid), 64'd1);
    chk("add_rs1", 64'(ba.out_rs1_data), 64'h1234);
    chk("add_rs2", 64'(ba.out_rs2_data), 64'h0);
    chk("add_imm", 64'(ba.out_imm), 64'h0);
    chk("add_b_rs1", bb.out_rs1_data, 64'h1234);
    in_valid = 1'b1; in_inst = 32'hFFF18113; in_pc = 32'h104;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'd7;
    tick;
    in_valid = 1'b0; wb_en = 1'b0;
    chk("addi_byp_rs1", 64'(ba.out_rs1_data), 64'd7);
    chk("addi_imm", 64'(ba.out_imm), 64'hFFFF_FFFF);
    chk("addi_nobyp_rs1", bb.out_rs1_data, 64'd0);
    chk("addi_b_imm", bb.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    in_valid = 1'b1; in_inst = 32'h00432423; in_pc = 32'h108;
    tick;
    chk("sw_imm", 64'(ba.out_imm), 64'd8);
    chk("sw_rs2_old", 64'(ba.out_rs2_data), 64'd0);
    out_ready = 1'b0; in_inst = 32'h01F09093; in_pc = 32'h10C;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'hAA;
    #1;
    chk("stall_in_ready", 64'(ba.in_ready), 64'd0);
    tick;
    wb_en = 1'b0;
    chk("stall_a_rs2", 64'(ba.out_rs2_data), 64'hAA);
    chk("stall_b_rs2", bb.out_rs2_data, 64'hAA);
    chk("stall_inst", 64'(ba.out_inst), 64'h00432423);
    chk("stall_valid", 64'(ba.out_valid), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    chk("release_valid", 64'(ba.out_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_inst = sw_inst[k]; in_pc = 32'h200 + 32'(k * 4);
      tick;
      chk("sweep_a_imm", 64'(ba.out_imm), sw_a[k]);
      chk("sweep_b_imm", bb.out_imm, sw_b[k]);
      chk("sweep_ill", 64'(ba.out_illegal), 64'(sw_ill[k]));
    end
    in_inst = 32'h000280B3;
    tick;
    out_ready = 1'b0; in_valid = 1'b0;
    tick;
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00000013;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'd5;
    #1;
    chk("flush_in_ready", 64'(ba.in_ready), 64'd0);
    tick;
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    chk("flush_valid", 64'(ba.out_valid), 64'd0);
    tick;
    chk("flush_valid2", 64'(ba.out_valid), 64'd0);
    dbg_addr = 5'd0;
    #1;
    chk("x0_dbg", 64'(ba.dbg_data), 64'd0);
    in_valid = 1'b1; in_inst = 32'h000000B3; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("x0_rs1", 64'(ba.out_rs1_data), 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h000280B3;
    #1;
    chk("flush_rdy_in_ready", 64'(ba.in_ready), 64'd0);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_rdy_valid", 64'(ba.out_valid), 64'd0);
    wb_en = 1'b1; wb_addr = 5'd20; wb_data = 64'd9;
    tick;
    wb_en = 1'b0; dbg_addr = 5'd20;
    #1;
    chk("x20_a_dbg", 64'(ba.dbg_data), 64'd9);
    chk("x20_b_dbg", bb.dbg_data, 64'd0);
    in_valid = 1'b1; in_inst = 32'h000A00B3;
    tick;
    in_valid = 1'b0;
    chk("x20_a_rs1", 64'(ba.out_rs1_data), 64'd9);
    chk("x20_b_rs1", bb.out_rs1_data, 64'd0);
    in_valid = 1'b1; in_inst = 32'h000280B3;
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_stall_valid", 64'(ba.out_valid), 64'd0);
    chk("rst_stall_rs1", 64'(ba.out_rs1_data), 64'd0);
    tick;
    tick;
    mon = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
